// File: rtl/alu_arb.sv
// alu_arb -- shares one combinational ALU between two requesters.
//
// Requester 0 is the execute stage, requester 1 the address/branch helper.
// One operation is in flight at a time: it is captured from the winning
// requester, presented to the ALU from a registered operand set, and the
// ALU result is registered and handed back to the owner over valid/ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         operation request handshake (N = 0, 1)
//   reqN_InA/InB/Cin/invA/invB/sign/Oper   operation fields
//   respN_valid/ready        result handshake, respN_valid only for owner
//   resp_Out/Zero/Ofl        registered result, shared by both requesters
//   alu_*  (out)             operand register driven to the ALU
//   alu_Out/Zero/Ofl (in)    ALU result
//   busy                     an operation is in EXEC or RESP
//   grant_cnt0/1             accepted-handshake counters
//
// Build option: define ALU_ARB_STATS_EN to build saturating 16-bit grant
// counters; otherwise grant_cnt0/1 are constant zero and no flops exist.
//
// state | meaning
// IDLE  | accepting a request, round-robin on contention
// EXEC  | operand register drives the ALU, result captured at the edge
// RESP  | result held for the owner until it asserts respN_ready

module alu_arb #(
    parameter int OPERAND_WIDTH  = 16,
    parameter int NUM_OPERATIONS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [OPERAND_WIDTH-1:0]  req0_InA,
    input  logic [OPERAND_WIDTH-1:0]  req0_InB,
    input  logic                      req0_Cin,
    input  logic                      req0_invA,
    input  logic                      req0_invB,
    input  logic                      req0_sign,
    input  logic [NUM_OPERATIONS-1:0] req0_Oper,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [OPERAND_WIDTH-1:0]  req1_InA,
    input  logic [OPERAND_WIDTH-1:0]  req1_InB,
    input  logic                      req1_Cin,
    input  logic                      req1_invA,
    input  logic                      req1_invB,
    input  logic                      req1_sign,
    input  logic [NUM_OPERATIONS-1:0] req1_Oper,
    output logic                      resp0_valid,
    input  logic                      resp0_ready,
    output logic                      resp1_valid,
    input  logic                      resp1_ready,
    output logic [OPERAND_WIDTH-1:0]  resp_Out,
    output logic                      resp_Zero,
    output logic                      resp_Ofl,
    output logic [OPERAND_WIDTH-1:0]  alu_InA,
    output logic [OPERAND_WIDTH-1:0]  alu_InB,
    output logic                      alu_Cin,
    output logic                      alu_invA,
    output logic                      alu_invB,
    output logic                      alu_sign,
    output logic [NUM_OPERATIONS-1:0] alu_Oper,
    input  logic [OPERAND_WIDTH-1:0]  alu_Out,
    input  logic                      alu_Zero,
    input  logic                      alu_Ofl,
    output logic                      busy,
    output logic [15:0]               grant_cnt0,
    output logic [15:0]               grant_cnt1
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                    state_q;
    logic                      ptr_q;
    logic                      owner_q;
    logic [OPERAND_WIDTH-1:0]  ina_q, inb_q;
    logic                      cin_q, inva_q, invb_q, sign_q;
    logic [NUM_OPERATIONS-1:0] oper_q;
    logic [OPERAND_WIDTH-1:0]  out_q;
    logic                      zero_q, ofl_q;

    logic gnt0, gnt1, consume;

    // A lone requester always wins; on contention the pointer decides.
    always_comb begin
        gnt0    = (state_q == IDLE) && req0_valid && (!req1_valid || !ptr_q);
        gnt1    = (state_q == IDLE) && req1_valid && (!req0_valid ||  ptr_q);
        consume = (state_q == RESP) && (owner_q ? resp1_ready : resp0_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            ina_q   <= '0;
            inb_q   <= '0;
            cin_q   <= 1'b0;
            inva_q  <= 1'b0;
            invb_q  <= 1'b0;
            sign_q  <= 1'b0;
            oper_q  <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            ofl_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        owner_q <= gnt1;
                        ina_q   <= gnt1 ? req1_InA  : req0_InA;
                        inb_q   <= gnt1 ? req1_InB  : req0_InB;
                        cin_q   <= gnt1 ? req1_Cin  : req0_Cin;
                        inva_q  <= gnt1 ? req1_invA : req0_invA;
                        invb_q  <= gnt1 ? req1_invB : req0_invB;
                        sign_q  <= gnt1 ? req1_sign : req0_sign;
                        oper_q  <= gnt1 ? req1_Oper : req0_Oper;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    out_q   <= alu_Out;
                    zero_q  <= alu_Zero;
                    ofl_q   <= alu_Ofl;
                    state_q <= RESP;
                end
                RESP: begin
                    if (consume) begin
                        ptr_q   <= ~owner_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_ready  = gnt0;
    assign req1_ready  = gnt1;
    assign resp0_valid = (state_q == RESP) && !owner_q;
    assign resp1_valid = (state_q == RESP) &&  owner_q;
    assign resp_Out    = out_q;
    assign resp_Zero   = zero_q;
    assign resp_Ofl    = ofl_q;
    assign busy        = (state_q != IDLE);

    assign alu_InA  = ina_q;
    assign alu_InB  = inb_q;
    assign alu_Cin  = cin_q;
    assign alu_invA = inva_q;
    assign alu_invB = invb_q;
    assign alu_sign = sign_q;
    assign alu_Oper = oper_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] gcnt0_q, gcnt1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            if (gnt0 && gcnt0_q != 16'hFFFF) gcnt0_q <= gcnt0_q + 16'd1;
            if (gnt1 && gcnt1_q != 16'hFFFF) gcnt1_q <= gcnt1_q + 16'd1;
        end
    end

    assign grant_cnt0 = gcnt0_q;
    assign grant_cnt1 = gcnt1_q;
`else
    assign grant_cnt0 = 16'h0000;
    assign grant_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_arb.sv
module tb_alu_arb;

    localparam int W  = 16;
    localparam int NO = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    v   = '0;
    logic [1:0]    rdy = '0;
    logic [W-1:0]  fa  [2];
    logic [W-1:0]  fb  [2];
    logic          fcin[2], fia[2], fib[2], fsg[2];
    logic [NO-1:0] fop [2];

    logic req0_ready, req1_ready, resp0_valid, resp1_valid, busy;
    logic [W-1:0] resp_Out, alu_InA, alu_InB, alu_Out;
    logic resp_Zero, resp_Ofl, alu_Cin, alu_invA, alu_invB, alu_sign, alu_Zero, alu_Ofl;
    logic [NO-1:0] alu_Oper;
    logic [15:0] grant_cnt0, grant_cnt1;

    int errors = 0;
    int checks = 0;
    int ptr_m  = 0;
    int cnt_m [2];

    alu_arb #(.OPERAND_WIDTH(W), .NUM_OPERATIONS(NO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v[0]), .req0_ready(req0_ready),
        .req0_InA(fa[0]), .req0_InB(fb[0]), .req0_Cin(fcin[0]), .req0_invA(fia[0]),
        .req0_invB(fib[0]), .req0_sign(fsg[0]), .req0_Oper(fop[0]),
        .req1_valid(v[1]), .req1_ready(req1_ready),
        .req1_InA(fa[1]), .req1_InB(fb[1]), .req1_Cin(fcin[1]), .req1_invA(fia[1]),
        .req1_invB(fib[1]), .req1_sign(fsg[1]), .req1_Oper(fop[1]),
        .resp0_valid(resp0_valid), .resp0_ready(rdy[0]),
        .resp1_valid(resp1_valid), .resp1_ready(rdy[1]),
        .resp_Out(resp_Out), .resp_Zero(resp_Zero), .resp_Ofl(resp_Ofl),
        .alu_InA(alu_InA), .alu_InB(alu_InB), .alu_Cin(alu_Cin), .alu_invA(alu_invA),
        .alu_invB(alu_invB), .alu_sign(alu_sign), .alu_Oper(alu_Oper),
        .alu_Out(alu_Out), .alu_Zero(alu_Zero), .alu_Ofl(alu_Ofl),
        .busy(busy), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    // Returns {Zero, Ofl, Out}. Oper 0 = add with inversion/carry, 1 AND, 2 OR, 3 XOR, else pass A.
    function automatic logic [W+1:0] alu_fn(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic cin, input logic ia, input logic ib,
                                            input logic sg, input logic [NO-1:0] op);
        logic [W-1:0] aa, bb, s;
        logic [W:0]   sum;
        logic         ofl;
        aa  = ia ? ~x : x;
        bb  = ib ? ~y : y;
        sum = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, cin};
        ofl = 1'b0;
        case (op)
            3'd0: begin
                s   = sum[W-1:0];
                ofl = sg ? ((aa[W-1] == bb[W-1]) && (s[W-1] != aa[W-1])) : sum[W];
            end
            3'd1:    s = aa & bb;
            3'd2:    s = aa | bb;
            3'd3:    s = aa ^ bb;
            default: s = aa;
        endcase
        return {(s == '0), ofl, s};
    endfunction

    // Stand-in for the shared combinational ALU.
    always_comb begin
        {alu_Zero, alu_Ofl, alu_Out} = alu_fn(alu_InA, alu_InB, alu_Cin, alu_invA,
                                              alu_invB, alu_sign, alu_Oper);
    end

    function automatic logic [W+1:0] expect_of(input int n);
        return alu_fn(fa[n], fb[n], fcin[n], fia[n], fib[n], fsg[n], fop[n]);
    endfunction

    task automatic set_fields(input int n, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic cin, input logic ia, input logic ib,
                              input logic sg, input logic [NO-1:0] op);
        fa[n] = x; fb[n] = y; fcin[n] = cin; fia[n] = ia; fib[n] = ib; fsg[n] = sg; fop[n] = op;
    endtask

    task automatic rand_fields(input int n);
        set_fields(n, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), NO'($urandom_range(0, 4)));
    endtask

    task automatic do_reset;
        rst = 1'b1; v = '0; rdy = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0; cnt_m[0] = 0; cnt_m[1] = 0;
    endtask

    // Drives one uncontested op from requester n and consumes it at once.
    task automatic run_op(input int n, output logic [W+1:0] got, output bit ok);
        ok = 1'b0; got = '0;
        @(negedge clk);
        v[n] = 1'b1;
        #1;
        if ((n == 0) ? !req0_ready : !req1_ready) begin
            v[n] = 1'b0;
            return;
        end
        @(negedge clk);
        v[n] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if ((n == 0) ? resp0_valid : resp1_valid) begin
                got = {resp_Zero, resp_Ofl, resp_Out};
                ok  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rdy[n] = 1'b1;
        @(negedge clk);
        rdy[n] = 1'b0;
        if (ok) begin
            ptr_m = 1 - n;
            cnt_m[n]++;
        end
    endtask

    task automatic test_reset;
        do_reset;
        #1;
        checks++;
        if ({busy, req0_ready, req1_ready, resp0_valid, resp1_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b exp 00000",
                               {busy, req0_ready, req1_ready, resp0_valid, resp1_valid});
        end
        checks++;
        if ({resp_Zero, resp_Ofl, resp_Out, alu_InA, alu_InB} !== '0) begin
            errors++; $display("FAIL reset_data: out %h z %b o %b ina %h inb %h exp all 0",
                               resp_Out, resp_Zero, resp_Ofl, alu_InA, alu_InB);
        end
        checks++;
        if ({grant_cnt0, grant_cnt1} !== 32'h0) begin
            errors++; $display("FAIL reset_cnt: got %h %h exp 0 0", grant_cnt0, grant_cnt1);
        end
        v = 2'b11;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++; $display("FAIL reset_prio: got %b exp 01", {req1_ready, req0_ready});
        end
        v = 2'b00;
    endtask

    task automatic test_single;
        @(negedge clk);
        set_fields(0, 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        v[0] = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++; $display("FAIL single_ready: got %b exp 01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        v[0] = 1'b0;
        #1;
        checks++;
        if ({busy, resp0_valid, alu_InA, alu_InB} !== {1'b1, 1'b0, 16'h0005, 16'h0003}) begin
            errors++; $display("FAIL single_exec: busy %b rv %b ina %h inb %h exp 1 0 0005 0003",
                               busy, resp0_valid, alu_InA, alu_InB);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({resp1_valid, resp0_valid, resp_Zero, resp_Ofl, resp_Out} !==
            {1'b0, 1'b1, 1'b0, 1'b0, 16'h0008}) begin
            errors++; $display("FAIL single_resp: rv %b%b z %b o %b out %h exp 01 0 0 0008",
                               resp1_valid, resp0_valid, resp_Zero, resp_Ofl, resp_Out);
        end
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
        #1;
        checks++;
        if ({busy, resp0_valid} !== 2'b00) begin
            errors++; $display("FAIL single_done: got %b exp 00", {busy, resp0_valid});
        end
        ptr_m = 1; cnt_m[0]++;
    endtask

    task automatic test_flags;
        logic [W+1:0] got;
        bit ok;
        set_fields(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        run_op(0, got, ok);
        checks++;
        if (!ok || got !== {1'b0, 1'b1, 16'h8000}) begin
            errors++; $display("FAIL flag_ofl: ok %0d got %h exp %h", ok, got, {1'b0, 1'b1, 16'h8000});
        end
        set_fields(1, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
        run_op(1, got, ok);
        checks++;
        if (!ok || got !== {1'b1, 1'b0, 16'h0000}) begin
            errors++; $display("FAIL flag_zero: ok %0d got %h exp %h", ok, got, {1'b1, 1'b0, 16'h0000});
        end
    endtask

    task automatic test_contention;
        logic [W+1:0] e;
        int exp;
        do_reset;
        rand_fields(0); rand_fields(1);
        v = 2'b11; rdy = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp = k % 2;
            e   = expect_of(exp);
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== ((exp == 1) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL contend_grant%0d: got %b exp owner %0d", k,
                                   {req1_ready, req0_ready}, exp);
            end
            @(negedge clk);
            #1;
            checks++;
            if ({busy, req1_ready, req0_ready} !== 3'b100) begin
                errors++; $display("FAIL contend_exec%0d: got %b exp 100", k,
                                   {busy, req1_ready, req0_ready});
            end
            @(negedge clk);
            #1;
            checks++;
            if ({resp1_valid, resp0_valid, resp_Zero, resp_Ofl, resp_Out} !==
                {((exp == 1) ? 2'b10 : 2'b01), e}) begin
                errors++; $display("FAIL contend_resp%0d: rv %b%b res %h exp owner %0d res %h", k,
                                   resp1_valid, resp0_valid, {resp_Zero, resp_Ofl, resp_Out}, exp, e);
            end
            @(negedge clk);
            cnt_m[exp]++;
            ptr_m = 1 - exp;
        end
        v = 2'b00; rdy = 2'b00;
    endtask

    task automatic test_backpressure;
        logic [W+1:0] e;
        @(negedge clk);
        set_fields(0, 16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
        e = expect_of(0);
        v[0] = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL bp_grant: got %b exp 1", req0_ready);
        end
        @(negedge clk);
        v = 2'b10;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({resp0_valid, resp1_valid, req0_ready, req1_ready, busy,
                 resp_Zero, resp_Ofl, resp_Out} !== {5'b10001, e}) begin
                errors++; $display("FAIL bp_hold%0d: ctl %b res %h exp 10001 %h", i,
                                   {resp0_valid, resp1_valid, req0_ready, req1_ready, busy},
                                   {resp_Zero, resp_Ofl, resp_Out}, e);
            end
            @(negedge clk);
        end
        v = 2'b00;
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
        #1;
        checks++;
        if ({busy, resp0_valid} !== 2'b00) begin
            errors++; $display("FAIL bp_release: got %b exp 00", {busy, resp0_valid});
        end
        ptr_m = 1; cnt_m[0]++;
    endtask

    task automatic test_reset_exec;
        @(negedge clk);
        rand_fields(0);
        v[0] = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL rexec_grant: got %b exp 1", req0_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1; v = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, resp0_valid, resp1_valid} !== 3'b000) begin
            errors++; $display("FAIL rexec_idle: got %b exp 000", {busy, resp0_valid, resp1_valid});
        end
        v = 2'b11;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++; $display("FAIL rexec_prio: got %b exp 01", {req1_ready, req0_ready});
        end
        v = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({resp0_valid, resp1_valid} !== 2'b00) begin
                errors++; $display("FAIL rexec_noresp%0d: got %b exp 00", i, {resp0_valid, resp1_valid});
            end
        end
        ptr_m = 0; cnt_m[0] = 0; cnt_m[1] = 0;
    endtask

    task automatic test_random;
        logic [W+1:0] e;
        int owner, stall;
        bit granted;
        do_reset;
        for (int op = 0; op < 60; op++) begin
            granted = 1'b0;
            owner   = 0;
            for (int t = 0; t < 50 && !granted; t++) begin
                if (t > 0) @(negedge clk);
                rdy = '0;
                rand_fields(0); rand_fields(1);
                v[0] = ($urandom_range(0, 3) != 0);
                v[1] = ($urandom_range(0, 3) != 0);
                #1;
                if (v[0] && v[1])  begin owner = ptr_m; granted = 1'b1; end
                else if (v[0])     begin owner = 0;     granted = 1'b1; end
                else if (v[1])     begin owner = 1;     granted = 1'b1; end
                checks++;
                if ({busy, req1_ready, req0_ready} !==
                    {1'b0, granted && owner == 1, granted && owner == 0}) begin
                    errors++; $display("FAIL rnd_grant%0d: got %b v %b ptr %0d", op,
                                       {busy, req1_ready, req0_ready}, v, ptr_m);
                end
            end
            if (!granted) begin
                errors++; checks++;
                $display("FAIL rnd_timeout%0d: no grant in 50 cycles exp a grant", op);
                return;
            end
            e = expect_of(owner);
            @(negedge clk);
            rand_fields(0); rand_fields(1);
            v = 2'($urandom);
            #1;
            checks++;
            if ({req1_ready, req0_ready, resp1_valid, resp0_valid} !== 4'b0000) begin
                errors++; $display("FAIL rnd_exec%0d: got %b exp 0000", op,
                                   {req1_ready, req0_ready, resp1_valid, resp0_valid});
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s <= stall; s++) begin
                @(negedge clk);
                #1;
                checks++;
                if ({resp1_valid, resp0_valid, req1_ready, req0_ready, resp_Zero, resp_Ofl, resp_Out} !==
                    {((owner == 1) ? 2'b10 : 2'b01), 2'b00, e}) begin
                    errors++; $display("FAIL rnd_resp%0d: rv %b%b res %h exp owner %0d res %h", op,
                                       resp1_valid, resp0_valid, {resp_Zero, resp_Ofl, resp_Out}, owner, e);
                end
                rdy[owner]     = (s == stall);
                rdy[1 - owner] = 1'($urandom);
            end
            cnt_m[owner]++;
            ptr_m = 1 - owner;
            @(negedge clk);
        end
        v = '0; rdy = '0;
        #1;
        checks++;
`ifdef ALU_ARB_STATS_EN
        if ({grant_cnt0, grant_cnt1} !== {16'(cnt_m[0]), 16'(cnt_m[1])}) begin
            errors++; $display("FAIL rnd_cnt: got %0d %0d exp %0d %0d",
                               grant_cnt0, grant_cnt1, cnt_m[0], cnt_m[1]);
        end
`else
        if ({grant_cnt0, grant_cnt1} !== 32'h0) begin
            errors++; $display("FAIL rnd_cnt_off: got %h %h exp 0 0", grant_cnt0, grant_cnt1);
        end
`endif
    endtask

    task automatic test_stats;
        logic [W+1:0] got;
        bit ok;
        do_reset;
        rand_fields(0); rand_fields(1);
        for (int i = 0; i < 5; i++) begin
            run_op((i < 3) ? 0 : 1, got, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL stats_op%0d: got no response exp response", i);
            end
        end
        #1;
        checks++;
`ifdef ALU_ARB_STATS_EN
        if ({grant_cnt0, grant_cnt1} !== {16'd3, 16'd2}) begin
            errors++; $display("FAIL stats_cnt: got %0d %0d exp 3 2", grant_cnt0, grant_cnt1);
        end
        @(negedge clk);
        force dut.gcnt0_q = 16'hFFFF;
        @(negedge clk);
        release dut.gcnt0_q;
        run_op(0, got, ok);
        #1;
        checks++;
        if (grant_cnt0 !== 16'hFFFF) begin
            errors++; $display("FAIL stats_sat: got %h exp FFFF", grant_cnt0);
        end
`else
        if ({grant_cnt0, grant_cnt1} !== 32'h0) begin
            errors++; $display("FAIL stats_off: got %h %h exp 0 0", grant_cnt0, grant_cnt1);
        end
`endif
    endtask

    initial begin
        cnt_m[0] = 0; cnt_m[1] = 0;
        for (int n = 0; n < 2; n++) set_fields(n, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        test_reset;
        test_single;
        test_flags;
        test_contention;
        test_backpressure;
        test_reset_exec;
        test_random;
        test_stats;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arb.md
Name: alu_arb

Overview:
- Arbitrates a single shared `alu` instance between two requesters: requester 0, the execute stage, and requester 1, the address/branch helper path.
- Captures one operation at a time, drives the ALU from a registered operand set, and registers the result.
- Returns the result to the owning requester over a valid/ready handshake.
- Sits beside the ALU in the execute stage; the ALU stays purely combinational.

Parameters:
- OPERAND_WIDTH, 16, width of operands and result (passed through to the ALU).
- NUM_OPERATIONS, 3, width of the Oper field.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- req{0,1}_valid  input  1  requester has an operation pending.
- req{0,1}_ready  output  1  arbiter accepts the operation this cycle.
- req{0,1}_InA, req{0,1}_InB  input  OPERAND_WIDTH  operands.
- req{0,1}_Cin, req{0,1}_invA, req{0,1}_invB, req{0,1}_sign  input  1  ALU controls.
- req{0,1}_Oper  input  NUM_OPERATIONS  operation code.
- resp{0,1}_valid  output  1  result available for that requester.
- resp{0,1}_ready  input  1  requester consumes the result.
- resp_Out  output  OPERAND_WIDTH  registered result, shared by both requesters.
- resp_Zero, resp_Ofl  output  1  registered ALU flags.
- alu_InA, alu_InB  output  OPERAND_WIDTH  to ALU.
- alu_Cin, alu_invA, alu_invB, alu_sign  output  1  to ALU.
- alu_Oper  output  NUM_OPERATIONS  to ALU.
- alu_Out  input  OPERAND_WIDTH  from ALU.
- alu_Zero, alu_Ofl  input  1  from ALU.
- busy  output  1  state != IDLE.
- grant_cnt0, grant_cnt1  output  16  grant statistics (see Optional Feature).

Behaviour:
- One clock `clk`; reset `rst` is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - state = IDLE, priority pointer = 0.
  - All req_ready and resp_valid = 0, busy = 0.
  - Operand register, resp_Out, resp_Zero and resp_Ofl = 0.
  - Grant counters = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If only one reqN_valid is high, reqN_ready = 1 combinationally.
  - If both are high, the requester equal to the priority pointer gets ready; the other sees ready = 0.
  - The handshake (valid & ready) latches all operand/control fields and owner = N, and moves to EXEC.
  - No valid: stay in IDLE.
- EXEC:
  - alu_* outputs are driven from the operand register.
  - At the clock edge, alu_Out/Zero/Ofl are captured into the resp_* registers; go to RESP.
- RESP:
  - resp{owner}_valid = 1; the other resp_valid = 0.
  - When resp{owner}_ready = 1: go to IDLE and set the priority pointer to ~owner (round robin).
  - Results hold stable until consumed; requesters may stall indefinitely.
- In IDLE and RESP the alu_* outputs still reflect the operand register, which holds its last value. They are don't-care to consumers.
- req_ready = 0 in EXEC and RESP; new requests wait.
- Latency: handshake at edge N, resp_valid high from cycle N+2. Minimum initiation interval is 3 cycles.
- resp_ready of the non-owner, and resp_ready while no response is pending, are ignored.
- Reset mid-operation (EXEC or RESP) discards the operation. No resp_valid is issued; state returns to IDLE with priority 0.
- A requester dropping valid before the handshake is allowed; nothing is latched.
- No combinational path from alu_* inputs to any output except through the resp registers.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - grant_cnt0/grant_cnt1 increment by 1 on each accepted handshake of requester 0/1.
  - They saturate at 16'hFFFF and reset to 0 on rst.
- Undefined: grant_cnt0/grant_cnt1 are tied to 16'h0000 and no counter flops are built. All other behaviour is identical.

Test Plan:
- Single request: req0 valid, InA=16'h0005, InB=16'h0003, add op; resp0_valid rises 2 cycles after the handshake, resp_Out=16'h0008, Zero=0, Ofl=0.
- Contention from reset: req0 and req1 both valid → req0 granted first. After resp0 is consumed, req1 is granted next and resp1_valid asserts. Order repeats 0,1,0,1 while both stay valid.
- Backpressure: hold resp0_ready=0 for 10 cycles → resp0_valid stays 1, resp_Out stays stable, req{0,1}_ready stay 0, busy=1. Release → IDLE next cycle.
- Flags: signed add of 16'h7FFF + 16'h0001 → resp_Ofl=1. Subtract equal operands → resp_Out=0, resp_Zero=1.
- Reset in EXEC: assert rst the cycle after the handshake → no resp_valid, busy=0, priority pointer=0 next cycle.
- ALU_ARB_STATS_EN:
  - Defined: 3 grants to req0 and 2 to req1 → grant_cnt0=3, grant_cnt1=2. Force the counter to 16'hFFFF, grant again → stays 16'hFFFF.
  - Undefined: both counters read 0.
